// File: rtl/data_ram.sv
// Single-port word RAM with a valid/ready request port and a fully pipelined,
// fixed-latency read response. Define DATA_RAM_CLEAR_EN to zero-fill memory after reset.
module data_ram #(
    parameter int D_ADDR_W       = 12,
    parameter int DATA_W         = 8,
    parameter int D_MEMORY_DEPTH = 1 << D_ADDR_W,
    parameter int READ_LATENCY   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [D_ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                init_done
);
    localparam int IDX_W = (D_MEMORY_DEPTH > 1) ? $clog2(D_MEMORY_DEPTH) : 1;

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t                   r_state;
    logic [DATA_W-1:0]        r_mem [D_MEMORY_DEPTH];
    logic [DATA_W-1:0]        r_dat [READ_LATENCY];
    logic [READ_LATENCY-1:0]  r_vld_pipe;
    logic [READ_LATENCY-1:0]  r_err_pipe;

    logic                     w_in_range;
    logic [IDX_W-1:0]         w_idx;
    logic                     w_acc;
    logic                     w_we;
    logic [IDX_W-1:0]         w_waddr;
    logic [DATA_W-1:0]        w_wdata;

    assign w_in_range = {1'b0, req_addr} < (D_ADDR_W+1)'(D_MEMORY_DEPTH);
    assign w_idx      = w_in_range ? req_addr[IDX_W-1:0] : '0;
    assign w_acc      = req_valid && (r_state == S_RUN);

`ifdef DATA_RAM_CLEAR_EN
    localparam int CNT_W = $clog2(D_MEMORY_DEPTH + 1);
    logic [CNT_W-1:0] r_clr_cnt;

    // In INIT the write port belongs to the clear sweep; requests are not accepted there.
    always_comb begin
        w_we    = w_acc && req_write && w_in_range;
        w_waddr = w_idx;
        w_wdata = req_wdata;
        if (r_state == S_INIT) begin
            w_we    = !rst && (r_clr_cnt < CNT_W'(D_MEMORY_DEPTH));
            w_waddr = r_clr_cnt[IDX_W-1:0];
            w_wdata = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_INIT;
            r_clr_cnt <= '0;
        end else if (r_state == S_INIT) begin
            if (r_clr_cnt == CNT_W'(D_MEMORY_DEPTH))
                r_state <= S_RUN;
            else
                r_clr_cnt <= r_clr_cnt + 1'b1;
        end
    end
`else
    assign w_we    = w_acc && req_write && w_in_range;
    assign w_waddr = w_idx;
    assign w_wdata = req_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_INIT;
        else
            r_state <= S_RUN;
    end
`endif

    // Memory and read-data pipe carry no reset; the output mux gates them with valid.
    always_ff @(posedge clk) begin
        if (w_we)
            r_mem[w_waddr] <= w_wdata;
        r_dat[0] <= r_mem[w_idx];
        for (int s = 1; s < READ_LATENCY; s++)
            r_dat[s] <= r_dat[s-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_pipe <= '0;
            r_err_pipe <= '0;
        end else begin
            r_vld_pipe[0] <= w_acc && !req_write;
            r_err_pipe[0] <= !w_in_range;
            for (int s = 1; s < READ_LATENCY; s++) begin
                r_vld_pipe[s] <= r_vld_pipe[s-1];
                r_err_pipe[s] <= r_err_pipe[s-1];
            end
        end
    end

    assign req_ready = (r_state == S_RUN);
    assign init_done = (r_state == S_RUN);
    assign rsp_valid = r_vld_pipe[READ_LATENCY-1];
    assign rsp_err   = r_vld_pipe[READ_LATENCY-1] && r_err_pipe[READ_LATENCY-1];
    assign rsp_rdata = (rsp_valid && !r_err_pipe[READ_LATENCY-1]) ? r_dat[READ_LATENCY-1] : '0;

endmodule

// File: tb/tb_data_ram.sv
// Bench for data_ram: three instances (depth/latency 16/1, 3000/2, 4096/3) share one
// request stream and are checked each cycle against an array/queue reference model.
module tb_data_ram;
    localparam int N = 3;
`ifdef DATA_RAM_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            req_valid = 1'b0, req_write = 1'b0;
    logic [11:0]     req_addr = '0;
    logic [7:0]      req_wdata = '0;
    logic [N-1:0]    req_ready, rsp_valid, rsp_err, init_done;
    logic [7:0]      rsp_rdata [N];

    always #5 clk = ~clk;

    data_ram #(.D_ADDR_W(12), .DATA_W(8), .D_MEMORY_DEPTH(16), .READ_LATENCY(1)) u0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready[0]),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
        .init_done(init_done[0]));
    data_ram #(.D_ADDR_W(12), .DATA_W(8), .D_MEMORY_DEPTH(3000), .READ_LATENCY(2)) u1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready[1]),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
        .init_done(init_done[1]));
    data_ram #(.D_ADDR_W(12), .DATA_W(8), .D_MEMORY_DEPTH(4096), .READ_LATENCY(3)) u2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready[2]),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]),
        .init_done(init_done[2]));

    int total = 0, bad = 0;
    int cyc = 0, es = 0;

    function automatic int dep(int i);
        return (i == 0) ? 16 : ((i == 1) ? 3000 : 4096);
    endfunction
    function automatic int lat(int i);
        return i + 1;
    endfunction
    function automatic int init_edges(int i);
        return CLR ? dep(i) + 1 : 1;
    endfunction

    task automatic chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s u%0d cyc=%0d got=%0h exp=%0h", nm, i, cyc, act, exp);
        end
    endtask

    // Reference model: a plain array per instance plus an ordered queue of due responses.
    typedef struct {
        int        inst;
        int        due;
        logic [7:0] d;
        bit        err;
        bit        known;
    } rsp_t;
    rsp_t        q[$];
    logic [7:0]  mm [N][4096];
    bit          mw [N][4096];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            es = 0;
            if (CLR)
                for (int i = 0; i < N; i++)
                    for (int a = 0; a < 4096; a++) mm[i][a] = 8'h00;
        end else begin
            cyc++;
            for (int i = 0; i < N; i++) begin
                if (es >= init_edges(i) && req_valid) begin
                    int   a;
                    rsp_t r;
                    a = int'(req_addr);
                    if (req_write) begin
                        if (a < dep(i)) begin
                            mm[i][a] = req_wdata;
                            mw[i][a] = 1'b1;
                        end
                    end else begin
                        r.inst  = i;
                        r.due   = cyc + lat(i) - 1;
                        r.err   = (a >= dep(i));
                        r.d     = r.err ? 8'h00 : mm[i][a];
                        r.known = r.err || CLR || mw[i][a];
                        q.push_back(r);
                    end
                end
            end
            es++;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            bit         ev, ee, kn;
            logic [7:0] ed;
            int         k;
            ev = 1'b0; ee = 1'b0; kn = 1'b1; ed = 8'h00; k = 0;
            while (k < q.size() && q[k].inst != i) k++;
            if (k < q.size() && q[k].due == cyc) begin
                ev = 1'b1; ee = q[k].err; ed = q[k].d; kn = q[k].known;
                q.delete(k);
            end
            chk("rsp_valid", i, 32'(rsp_valid[i]), 32'(ev));
            chk("rsp_err", i, 32'(rsp_err[i]), 32'(ee));
            if (kn) chk("rsp_rdata", i, 32'(rsp_rdata[i]), 32'(ed));
            chk("init_done", i, 32'(init_done[i]), 32'(es >= init_edges(i)));
            chk("req_ready", i, 32'(req_ready[i]), 32'(es >= init_edges(i)));
        end
    end

    task automatic drv(bit v, bit w, int a, int d);
        @(negedge clk);
        req_valid = v; req_write = w; req_addr = 12'(a); req_wdata = 8'(d);
    endtask
    task automatic wr(int a, int d); drv(1'b1, 1'b1, a, d); endtask
    task automatic rd(int a);        drv(1'b1, 1'b0, a, 0); endtask
    task automatic idle();           drv(1'b0, 1'b0, 0, 0); endtask

    task automatic reset_and_init();
        int n, n0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 0, 32'(req_ready), 32'h0);
        chk("rst_valid", 0, 32'(rsp_valid), 32'h0);
        chk("rst_err", 0, 32'(rsp_err), 32'h0);
        chk("rst_init", 0, 32'(init_done), 32'h0);
        chk("rst_rdata", 0, {rsp_rdata[0], rsp_rdata[1], rsp_rdata[2]}, 32'h0);
        rst = 1'b0;
        n = 0; n0 = -1;
        while (!(&init_done) && n < 6000) begin
            @(negedge clk);
            n++;
            if (init_done[0] && n0 < 0) n0 = n;
        end
        chk("init_timeout", 0, 32'(n < 6000), 32'h1);
        chk("init_edges", 0, 32'(n0), CLR ? 32'd17 : 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        reset_and_init();

        // Sweep the 16-word instance right after init (zero when the clear sweep is built in).
        for (int a = 0; a < 16; a++) rd(a);
        repeat (5) idle();

        // Write then read one cycle later, latency-2 instance.
        wr(3, 8'hA5);
        rd(3);
        idle();
        chk("a5_u0", 0, 32'(rsp_rdata[0]), 32'hA5);
        chk("a5_early", 1, 32'(rsp_valid[1]), 32'h0);
        @(negedge clk);
        chk("a5_vld", 1, 32'(rsp_valid[1]), 32'h1);
        chk("a5_data", 1, 32'(rsp_rdata[1]), 32'hA5);
        chk("a5_err", 1, 32'(rsp_err[1]), 32'h0);
        repeat (3) idle();

        // Out-of-range write/read at 3000 on the 3000-deep instance.
        wr(0, 8'h3C);
        wr(12'hBB8, 8'h55);
        rd(12'hBB8);
        rd(0);
        idle();
        chk("oor_err", 1, 32'(rsp_err[1]), 32'h1);
        chk("oor_data", 1, 32'(rsp_rdata[1]), 32'h0);
        @(negedge clk);
        chk("oor_a0_err", 1, 32'(rsp_err[1]), 32'h0);
        chk("oor_a0_data", 1, 32'(rsp_rdata[1]), 32'h3C);
        repeat (3) idle();

        // Back-to-back reads through the latency-3 instance.
        wr(1, 8'h11); wr(2, 8'h22); wr(3, 8'h33);
        rd(1); rd(2); rd(3);
        idle();
        chk("b2b_0", 2, {23'h0, rsp_valid[2], rsp_rdata[2]}, 32'h111);
        @(negedge clk);
        chk("b2b_1", 2, {23'h0, rsp_valid[2], rsp_rdata[2]}, 32'h122);
        @(negedge clk);
        chk("b2b_2", 2, {23'h0, rsp_valid[2], rsp_rdata[2]}, 32'h133);
        @(negedge clk);
        chk("b2b_end", 2, 32'(rsp_valid[2]), 32'h0);
        idle();

        // Address 0x010 is in range for u1/u2 but one past the end of u0.
        wr(12'h010, 8'h7E);
        rd(12'h010);
        idle();
        chk("7e_u0_err", 0, 32'(rsp_err[0]), 32'h1);
        @(negedge clk);
        chk("7e_u1", 1, 32'(rsp_rdata[1]), 32'h7E);
        repeat (3) idle();

        // Mixed table of writes then reads, including out-of-range addresses per instance.
        for (int i = 0; i < 12; i++) wr((i * 37 + 5) % 4096, i * 13 + 7);
        wr(12'hFFF, 8'hC3);
        wr(12'hBB7, 8'h9D);
        for (int i = 11; i >= 0; i--) rd((i * 37 + 5) % 4096);
        rd(12'hFFF); rd(12'hBB7); rd(4000); rd(15); rd(16);
        repeat (6) idle();

        // Async reset with reads in flight: everything drops at once, nothing stale afterwards.
        rd(1); rd(2);
        idle();
        chk("inflight", 0, 32'(rsp_valid[0]), 32'h1);
        #2 rst = 1'b1;
        #1 chk("rst_async_vld", 0, 32'(rsp_valid), 32'h0);
        chk("rst_async_rdy", 0, 32'(req_ready), 32'h0);
        reset_and_init();
        repeat (10) idle();
        wr(5, 8'h5A);
        rd(5);
        repeat (5) idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/data_ram.md
DATA_RAM -- requirements
Module: data_ram

Interface
REQ-001 SHALL have parameter D_ADDR_W, default 12, meaning address width in bits.
REQ-002 SHALL have parameter DATA_W, default 8, meaning data word width in bits.
REQ-003 SHALL have parameter D_MEMORY_DEPTH, default 1 << D_ADDR_W, meaning number of implemented words (legal range 1..2^D_ADDR_W).
REQ-004 SHALL have parameter READ_LATENCY, default 1, meaning cycles from read acceptance to rsp_valid (legal range 1..3).
REQ-005 SHALL use one clock; reset is asynchronous and active-high.
REQ-006 SHALL have port clk, input, 1, rising-edge clock.
REQ-007 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port req_valid, input, 1, request present.
REQ-009 SHALL have port req_ready, output, 1, request accepted this cycle if req_valid is high.
REQ-010 SHALL have port req_write, input, 1, 1 = write, 0 = read.
REQ-011 SHALL have port req_addr, input, D_ADDR_W, word address.
REQ-012 SHALL have port req_wdata, input, DATA_W, write data.
REQ-013 SHALL have port rsp_valid, output, 1, read data valid (single-cycle pulse per read).
REQ-014 SHALL have port rsp_rdata, output, DATA_W, read data.
REQ-015 SHALL have port rsp_err, output, 1, qualifies rsp_valid; out-of-range read.
REQ-016 SHALL have port init_done, output, 1, high once memory is usable.

Function
REQ-017 SHALL implement a two-state FSM: INIT, then RUN; req_ready = 1 only in RUN.
REQ-018 SHALL treat a request as accepted on a rising edge where req_valid && req_ready.
REQ-019 SHALL, on an accepted write with req_addr < D_MEMORY_DEPTH, update mem[req_addr] at that edge; no response is generated for writes.
REQ-020 SHALL ignore accepted writes with req_addr >= D_MEMORY_DEPTH; memory is unchanged and no response is generated.
REQ-021 SHALL, on an accepted read, assert rsp_valid for exactly one cycle, READ_LATENCY cycles after acceptance, with rsp_rdata = the word stored at acceptance time.
REQ-022 SHALL return rsp_rdata = 0 and rsp_err = 1 for reads with req_addr >= D_MEMORY_DEPTH; rsp_err = 0 otherwise.
REQ-023 SHALL hold rsp_rdata at 0 and rsp_err at 0 while rsp_valid is 0; the bus never floats.
REQ-024 SHALL accept one request per cycle back-to-back; a read one cycle after a write to the same address returns the new data.
REQ-025 SHALL pipeline reads fully, so READ_LATENCY reads may be in flight with responses delivered in acceptance order.
REQ-026 SHALL drive init_done = 1 exactly when the FSM is in RUN.

Reset
REQ-027 SHALL, while rst is high, force the FSM to INIT and set req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, and init_done = 0.
REQ-028 SHALL discard all in-flight read responses when rst is asserted mid-operation; no rsp_valid appears after reset for pre-reset reads.
REQ-029 SHALL NOT reset memory contents directly via rst; contents are governed by REQ-030/REQ-031.

Configuration
REQ-030 SHALL, with DATA_RAM_CLEAR_EN defined, clear memory in INIT after rst deasserts: write 0 to address k on the k-th clk edge, k = 0..D_MEMORY_DEPTH-1; move to RUN on the edge after the last address; init_done rises D_MEMORY_DEPTH+1 edges after rst deasserts.
REQ-031 SHALL, without DATA_RAM_CLEAR_EN, move from INIT to RUN on the first clk edge after rst deasserts; memory contents are undefined until written.

Verification
REQ-032 SHALL cover: DATA_RAM_CLEAR_EN defined, D_MEMORY_DEPTH=16, rst pulse -> init_done high 17 edges after rst deasserts; read of all 16 addresses -> all 0.
REQ-033 SHALL cover: READ_LATENCY=2, write 0xA5 @0x003, then a read @0x003 on the next cycle -> rsp_valid 2 cycles after read acceptance with rsp_rdata = 0xA5 and rsp_err = 0.
REQ-034 SHALL cover: D_MEMORY_DEPTH=3000, write 0x55 @0xBB8, then read @0xBB8 -> rsp_rdata = 0x00, rsp_err = 1; read @0x000 -> unaffected.
REQ-035 SHALL cover: READ_LATENCY=3, back-to-back reads @1, @2, @3 holding 0x11, 0x22, 0x33 -> three consecutive rsp_valid cycles returning 0x11, 0x22, 0x33 in order.
REQ-036 SHALL cover: two reads in flight, rst asserted asynchronously -> rsp_valid = 0 immediately and no stale response after rst deasserts.
REQ-037 SHALL cover: DATA_RAM_CLEAR_EN undefined, rst deasserts -> init_done and req_ready = 1 after one edge; write 0x7E @0x010 then read -> 0x7E.
